// File: rtl/ysyx_22041752_trap_ctrl_pkg.sv
// Shared definitions for the trap controller: CSR addresses, mstatus fields, FSM encoding.
package ysyx_22041752_trap_ctrl_pkg;
  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS = 12'h300;
  localparam csr_addr_t CSR_MTVEC   = 12'h305;
  localparam csr_addr_t CSR_MEPC    = 12'h341;
  localparam csr_addr_t CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_EPC   = 3'd1,
    T_CAUSE = 3'd2,
    T_STAT  = 3'd3,
    T_JUMP  = 3'd4,
    R_STAT  = 3'd5,
    R_JUMP  = 3'd6
  } trap_state_e;
endpackage

// File: rtl/ysyx_22041752_trap_ctrl_if.sv
// Single-port CSR-file bus; the trap controller is its only master.
interface ysyx_22041752_trap_ctrl_if;
  import ysyx_22041752_trap_ctrl_pkg::*;
  logic        wen;
  csr_addr_t   addr;
  logic [63:0] wdata;
  logic [63:0] rdata;

  modport master (output wen, addr, wdata, input rdata);
  modport slave  (input wen, addr, wdata, output rdata);
endinterface

// File: rtl/ysyx_22041752_trap_ctrl.sv
// Trap/mret sequencer that owns the CSR-file port and lends it to pipeline CSR
// instructions only while idle.
module ysyx_22041752_trap_ctrl
  import ysyx_22041752_trap_ctrl_pkg::*;
#(
  parameter logic [63:0] CAUSE_ECALL = 64'd11,
  parameter logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_i,
  input  logic [63:0] ex_pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        int_t_i,
  input  logic        csr_req_i,
  input  logic        csr_wen_i,
  input  csr_addr_t   csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  output logic [63:0] csr_rdata_o,
  output logic        csr_ack_o,
  output logic        csr_wen_o,
  output csr_addr_t   csr_addr_o,
  output logic [63:0] csr_wdata_o,
  input  logic [63:0] csr_rdata_i,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o
);

  trap_state_e state, state_nxt;
  logic [63:0] pc_q, cause_q;
  logic        trap_acc, mret_acc;

  function automatic logic [63:0] trap_mstatus(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mret_mstatus(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  assign trap_acc = (state == IDLE) && ex_valid_i && (int_t_i || ecall_i);
  assign mret_acc = (state == IDLE) && ex_valid_i && !int_t_i && !ecall_i && mret_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state <= state_nxt;
      if (trap_acc) begin
        pc_q    <= ex_pc_i;
        cause_q <= int_t_i ? CAUSE_MTI : CAUSE_ECALL;
      end
    end
  end

  // Outputs are gated by reset so an asserted reset silences the CSR port at once.
  always_comb begin
    state_nxt     = state;
    stall_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    csr_wen_o     = 1'b0;
    csr_addr_o    = '0;
    csr_wdata_o   = '0;
    csr_ack_o     = 1'b0;
    csr_rdata_o   = '0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (trap_acc) begin
            state_nxt = T_EPC;
            stall_o   = 1'b1;
          end else if (mret_acc) begin
            state_nxt = R_STAT;
            stall_o   = 1'b1;
          end else if (csr_req_i) begin
            csr_wen_o   = csr_wen_i;
            csr_addr_o  = csr_addr_i;
            csr_wdata_o = csr_wdata_i;
            csr_ack_o   = 1'b1;
            csr_rdata_o = csr_rdata_i;
          end
        end
        T_EPC: begin
          state_nxt = T_CAUSE;
          stall_o = 1'b1; csr_wen_o = 1'b1; csr_addr_o = CSR_MEPC; csr_wdata_o = pc_q;
        end
        T_CAUSE: begin
          state_nxt = T_STAT;
          stall_o = 1'b1; csr_wen_o = 1'b1; csr_addr_o = CSR_MCAUSE; csr_wdata_o = cause_q;
        end
        T_STAT: begin
          state_nxt = T_JUMP;
          stall_o = 1'b1; csr_wen_o = 1'b1; csr_addr_o = CSR_MSTATUS;
          csr_wdata_o = trap_mstatus(csr_rdata_i);
        end
        T_JUMP: begin
          state_nxt = IDLE;
          stall_o = 1'b1; csr_addr_o = CSR_MTVEC;
          redirect_o = 1'b1; redirect_pc_o = {csr_rdata_i[63:2], 2'b00};
        end
        R_STAT: begin
          state_nxt = R_JUMP;
          stall_o = 1'b1; csr_wen_o = 1'b1; csr_addr_o = CSR_MSTATUS;
          csr_wdata_o = mret_mstatus(csr_rdata_i);
        end
        R_JUMP: begin
          state_nxt = IDLE;
          stall_o = 1'b1; csr_addr_o = CSR_MEPC;
          redirect_o = 1'b1; redirect_pc_o = csr_rdata_i;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_trap_ctrl.sv
// Directed bench: arbitration table in IDLE plus hand-written trap/mret/reset sequences.
module tb_ysyx_22041752_trap_ctrl;
  import ysyx_22041752_trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid_i = 0, ecall_i = 0, mret_i = 0, int_t_i = 0;
  logic [63:0] ex_pc_i = '0;
  logic        csr_req_i = 0, csr_wen_i = 0;
  csr_addr_t   csr_addr_i = '0;
  logic [63:0] csr_wdata_i = '0;
  logic [63:0] csr_rdata_o, redirect_pc_o;
  logic        csr_ack_o, stall_o, redirect_o;

  ysyx_22041752_trap_ctrl_if csr_bus();

  ysyx_22041752_trap_ctrl dut (
    .clk(clk), .reset(reset),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ecall_i(ecall_i), .mret_i(mret_i),
    .int_t_i(int_t_i),
    .csr_req_i(csr_req_i), .csr_wen_i(csr_wen_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_ack_o(csr_ack_o),
    .csr_wen_o(csr_bus.wen), .csr_addr_o(csr_bus.addr), .csr_wdata_o(csr_bus.wdata),
    .csr_rdata_i(csr_bus.rdata),
    .stall_o(stall_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  // Behavioural CSR file with a bench-side preload port.
  logic [63:0] r_mstatus = '0, r_mtvec = '0, r_mepc = '0, r_mcause = '0;
  logic        pre_we = 0;
  csr_addr_t   pre_addr = '0;
  logic [63:0] pre_data = '0;

  always_comb begin
    csr_bus.rdata = '0;
    case (csr_bus.addr)
      CSR_MSTATUS: csr_bus.rdata = r_mstatus;
      CSR_MTVEC:   csr_bus.rdata = r_mtvec;
      CSR_MEPC:    csr_bus.rdata = r_mepc;
      CSR_MCAUSE:  csr_bus.rdata = r_mcause;
      default:     csr_bus.rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_bus.wen || pre_we) begin
      case (pre_we ? pre_addr : csr_bus.addr)
        CSR_MSTATUS: r_mstatus <= pre_we ? pre_data : csr_bus.wdata;
        CSR_MTVEC:   r_mtvec   <= pre_we ? pre_data : csr_bus.wdata;
        CSR_MEPC:    r_mepc    <= pre_we ? pre_data : csr_bus.wdata;
        CSR_MCAUSE:  r_mcause  <= pre_we ? pre_data : csr_bus.wdata;
        default: ;
      endcase
    end
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic preload(input csr_addr_t a, input logic [63:0] d);
    @(negedge clk);
    pre_we = 1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 0;
  endtask

  task automatic clear_in();
    ex_valid_i = 0; ecall_i = 0; mret_i = 0; int_t_i = 0;
    csr_req_i = 0; csr_wen_i = 0; csr_addr_i = '0; csr_wdata_i = '0;
  endtask

  task automatic step();
    @(negedge clk); #2;
  endtask

  // Full trap sequence from accept (N) to IDLE (N+5), checking each cycle.
  task automatic run_trap(input string nm, input logic [63:0] pc, input logic it,
                          input logic ec, input logic [63:0] exp_cause,
                          input logic [63:0] exp_stat, input logic [63:0] exp_tgt);
    step();
    ex_valid_i = 1; ex_pc_i = pc; int_t_i = it; ecall_i = ec; #1;
    chk({nm, " accept stall"}, 64'(stall_o), 64'd1);
    step(); clear_in();
    chk({nm, " N+1 addr"}, 64'(csr_bus.addr), 64'(CSR_MEPC));
    chk({nm, " N+1 wdata"}, csr_bus.wdata, pc);
    step();
    chk({nm, " N+2 wdata"}, csr_bus.wdata, exp_cause);
    step();
    chk({nm, " N+3 addr"}, 64'(csr_bus.addr), 64'(CSR_MSTATUS));
    chk({nm, " N+3 wdata"}, csr_bus.wdata, exp_stat);
    step();
    chk({nm, " N+4 redirect"}, 64'(redirect_o), 64'd1);
    chk({nm, " N+4 pc"}, redirect_pc_o, exp_tgt);
    chk({nm, " N+4 wen"}, 64'(csr_bus.wen), 64'd0);
    step();
    chk({nm, " N+5 stall"}, 64'(stall_o), 64'd0);
    chk({nm, " N+5 redirect"}, 64'(redirect_o), 64'd0);
    chk({nm, " mepc"}, r_mepc, pc);
    chk({nm, " mcause"}, r_mcause, exp_cause);
    chk({nm, " mstatus"}, r_mstatus, exp_stat);
  endtask

  typedef struct {
    logic      ev, it, ec, mr, req, wen;
    csr_addr_t addr;
    logic      e_stall, e_ack, e_wen;
    csr_addr_t e_addr;
  } vec_t;

  vec_t vt[8];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    //          ev it ec mr req wen addr         stall ack wen e_addr
    vt[0] = '{0, 0, 0, 0, 0,  0,  12'h000,      0,    0,  0,  12'h000};
    vt[1] = '{0, 0, 0, 0, 1,  0,  CSR_MTVEC,    0,    1,  0,  CSR_MTVEC};
    vt[2] = '{1, 0, 0, 0, 1,  1,  CSR_MEPC,     0,    1,  1,  CSR_MEPC};
    vt[3] = '{1, 0, 1, 0, 0,  0,  12'h000,      1,    0,  0,  12'h000};
    vt[4] = '{0, 1, 1, 1, 1,  0,  CSR_MSTATUS,  0,    1,  0,  CSR_MSTATUS};
    vt[5] = '{1, 0, 0, 1, 1,  1,  CSR_MTVEC,    1,    0,  0,  12'h000};
    vt[6] = '{1, 1, 0, 0, 1,  1,  CSR_MCAUSE,   1,    0,  0,  12'h000};
    vt[7] = '{1, 0, 1, 1, 1,  1,  CSR_MEPC,     1,    0,  0,  12'h000};

    // Reset state, with a pipeline request pending that must stay masked.
    csr_req_i = 1; csr_wen_i = 1; csr_addr_i = CSR_MTVEC; csr_wdata_i = 64'h1234;
    #3;
    chk("rst ack", 64'(csr_ack_o), 64'd0);
    chk("rst wen", 64'(csr_bus.wen), 64'd0);
    chk("rst addr", 64'(csr_bus.addr), 64'd0);
    chk("rst stall", 64'(stall_o), 64'd0);
    clear_in();
    step(); reset = 1;

    // IDLE arbitration table; inputs are withdrawn before the edge.
    for (int i = 0; i < 8; i++) begin
      step();
      ex_valid_i = vt[i].ev; int_t_i = vt[i].it; ecall_i = vt[i].ec; mret_i = vt[i].mr;
      csr_req_i = vt[i].req; csr_wen_i = vt[i].wen; csr_addr_i = vt[i].addr;
      csr_wdata_i = 64'hdead_0000 + 64'(i);
      #1;
      chk($sformatf("vec%0d stall", i), 64'(stall_o), 64'(vt[i].e_stall));
      chk($sformatf("vec%0d ack", i), 64'(csr_ack_o), 64'(vt[i].e_ack));
      chk($sformatf("vec%0d wen", i), 64'(csr_bus.wen), 64'(vt[i].e_wen));
      chk($sformatf("vec%0d addr", i), 64'(csr_bus.addr), 64'(vt[i].e_addr));
      clear_in(); #1;
    end

    // ecall trap
    preload(CSR_MSTATUS, 64'h0a_0000_1808);
    preload(CSR_MTVEC, 64'h8000_0000);
    run_trap("ecall", 64'h8000_0100, 0, 1, 64'd11, 64'h0a_0000_1880, 64'h8000_0000);

    // Interrupt wins over ecall; mtvec low bits masked off the target.
    preload(CSR_MSTATUS, 64'h0a_0000_1808);
    preload(CSR_MTVEC, 64'h8000_0003);
    run_trap("int", 64'h8000_0200, 1, 1, 64'h8000_0000_0000_0007, 64'h0a_0000_1880,
             64'h8000_0000);

    // mret
    preload(CSR_MEPC, 64'h8000_0104);
    preload(CSR_MSTATUS, 64'h0000_0080);
    step();
    ex_valid_i = 1; mret_i = 1; #1;
    chk("mret accept stall", 64'(stall_o), 64'd1);
    step(); clear_in();
    chk("mret N+1 addr", 64'(csr_bus.addr), 64'(CSR_MSTATUS));
    chk("mret N+1 wdata", csr_bus.wdata, 64'h0000_1888);
    step();
    chk("mret N+2 redirect", 64'(redirect_o), 64'd1);
    chk("mret N+2 pc", redirect_pc_o, 64'h8000_0104);
    step();
    chk("mret N+3 stall", 64'(stall_o), 64'd0);
    chk("mret mstatus", r_mstatus, 64'h0000_1888);

    // Pipeline CSR write in IDLE
    step();
    csr_req_i = 1; csr_wen_i = 1; csr_addr_i = CSR_MTVEC; csr_wdata_i = 64'h8000_1000; #1;
    chk("idle wr ack", 64'(csr_ack_o), 64'd1);
    chk("idle wr wdata", csr_bus.wdata, 64'h8000_1000);
    step(); clear_in();
    chk("idle wr mtvec", r_mtvec, 64'h8000_1000);

    // Pipeline request held from T_CAUSE until served in IDLE
    preload(CSR_MSTATUS, 64'h0000_1808);
    step();
    ex_valid_i = 1; ecall_i = 1; ex_pc_i = 64'h8000_0300;
    step(); clear_in();
    step();
    csr_req_i = 1; csr_wen_i = 1; csr_addr_i = CSR_MTVEC; csr_wdata_i = 64'h8000_2000; #1;
    chk("busy T_CAUSE ack", 64'(csr_ack_o), 64'd0);
    chk("busy T_CAUSE wdata", csr_bus.wdata, 64'd11);
    step();
    chk("busy T_STAT ack", 64'(csr_ack_o), 64'd0);
    chk("busy T_STAT wdata", csr_bus.wdata, 64'h0000_1880);
    step();
    chk("busy T_JUMP ack", 64'(csr_ack_o), 64'd0);
    chk("busy T_JUMP pc", redirect_pc_o, 64'h8000_1000);
    step();
    chk("busy idle ack", 64'(csr_ack_o), 64'd1);
    step(); clear_in();
    chk("busy mtvec", r_mtvec, 64'h8000_2000);
    chk("busy mcause", r_mcause, 64'd11);
    chk("busy mepc", r_mepc, 64'h8000_0300);

    // Reset during T_STAT
    preload(CSR_MSTATUS, 64'h0000_0008);
    step();
    ex_valid_i = 1; ecall_i = 1; ex_pc_i = 64'h8000_0400;
    step(); clear_in();
    step(); step();
    chk("pre-rst T_STAT wen", 64'(csr_bus.wen), 64'd1);
    reset = 0; #1;
    chk("rst mid wen", 64'(csr_bus.wen), 64'd0);
    chk("rst mid stall", 64'(stall_o), 64'd0);
    chk("rst mid addr", 64'(csr_bus.addr), 64'd0);
    step(); reset = 1; #1;
    chk("rst rel stall", 64'(stall_o), 64'd0);
    chk("rst mstatus", r_mstatus, 64'h0000_0008);
    step();
    chk("rst idle redirect", 64'(redirect_o), 64'd0);
    csr_req_i = 1; csr_addr_i = CSR_MSTATUS; #1;
    chk("rst idle ack", 64'(csr_ack_o), 64'd1);
    chk("rst idle rdata", csr_rdata_o, 64'h0000_0008);
    clear_in();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
